// File: rtl/pipe_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_mem_arbiter_if
//  Brief    : Bundles the CPU MEM-stage, DMA and data-memory buses of the arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
interface pipe_mem_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              cpu_wmem;
    logic              cpu_rmem;
    logic [ADDR_W-1:0] cpu_addr;
    logic [31:0]       cpu_wdata;
    logic              cpu_stall;
    logic              cpu_rvalid;
    logic [31:0]       cpu_rdata;

    logic              dma_valid;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [31:0]       dma_wdata;
    logic              dma_ready;
    logic              dma_rvalid;
    logic [31:0]       dma_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    logic [15:0]       stall_cnt;

    // Environment side: pipeline, DMA engine and the memory macro.
    modport master (
        output cpu_wmem, cpu_rmem, cpu_addr, cpu_wdata,
        input  cpu_stall, cpu_rvalid, cpu_rdata,
        output dma_valid, dma_we, dma_addr, dma_wdata,
        input  dma_ready, dma_rvalid, dma_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  stall_cnt
    );

    // Arbiter side.
    modport slave (
        input  cpu_wmem, cpu_rmem, cpu_addr, cpu_wdata,
        output cpu_stall, cpu_rvalid, cpu_rdata,
        input  dma_valid, dma_we, dma_addr, dma_wdata,
        output dma_ready, dma_rvalid, dma_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output stall_cnt
    );
endinterface
`default_nettype wire

// File: rtl/pipe_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_mem_arbiter
//  Brief    : CPU-priority arbiter for the single-port data memory with DMA
//             starvation guard, pipeline stall and registered read routing.
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_mem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clock,
    input  logic              resetn,
    pipe_mem_arbiter_if.slave bus
);
    localparam logic [3:0]  c_MAX_WAIT  = 4'(MAX_WAIT);
    localparam logic [15:0] c_STALL_MAX = 16'hFFFF;

    logic              w_cpu_req;
    logic              w_dma_grant;
    logic              w_cpu_grant;
    logic              w_cpu_stall;
    logic              w_mem_en;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [31:0]       w_mem_wdata;

    logic [3:0]        r_wait_cnt;
    logic              r_cpu_rd_q;
    logic              r_dma_rd_q;
    logic [15:0]       r_stall_cnt;

    // DMA only wins against a live CPU request once it has waited MAX_WAIT cycles.
    assign w_cpu_req   = bus.cpu_wmem | bus.cpu_rmem;
    assign w_dma_grant = bus.dma_valid & (~w_cpu_req | (r_wait_cnt == c_MAX_WAIT));
    assign w_cpu_grant = w_cpu_req & ~w_dma_grant;
    assign w_cpu_stall = w_cpu_req & ~w_cpu_grant;

    always_comb begin
        w_mem_en    = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        if (w_dma_grant) begin
            w_mem_en    = 1'b1;
            w_mem_we    = bus.dma_we;
            w_mem_addr  = bus.dma_addr;
            w_mem_wdata = bus.dma_wdata;
        end else if (w_cpu_grant) begin
            w_mem_en    = 1'b1;
            w_mem_we    = bus.cpu_wmem;
            w_mem_addr  = bus.cpu_addr;
            w_mem_wdata = bus.cpu_wdata;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_wait_cnt <= 4'd0;
        end else if (w_dma_grant || !bus.dma_valid) begin
            r_wait_cnt <= 4'd0;
        end else if (r_wait_cnt != c_MAX_WAIT) begin
            r_wait_cnt <= r_wait_cnt + 4'd1;
        end
    end

    // Read flags mark whose data the memory returns on the following cycle.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_cpu_rd_q <= 1'b0;
            r_dma_rd_q <= 1'b0;
        end else begin
            r_cpu_rd_q <= w_cpu_grant & ~bus.cpu_wmem;
            r_dma_rd_q <= w_dma_grant & ~bus.dma_we;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_stall_cnt <= 16'd0;
        end else if (w_cpu_stall && (r_stall_cnt != c_STALL_MAX)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign bus.mem_en     = w_mem_en;
    assign bus.mem_we     = w_mem_we;
    assign bus.mem_addr   = w_mem_addr;
    assign bus.mem_wdata  = w_mem_wdata;

    assign bus.cpu_stall  = w_cpu_stall;
    assign bus.cpu_rvalid = r_cpu_rd_q;
    assign bus.cpu_rdata  = r_cpu_rd_q ? bus.mem_rdata : 32'd0;

    assign bus.dma_ready  = w_dma_grant;
    assign bus.dma_rvalid = r_dma_rd_q;
    assign bus.dma_rdata  = r_dma_rd_q ? bus.mem_rdata : 32'd0;

    assign bus.stall_cnt  = r_stall_cnt;
endmodule
`default_nettype wire
